mips_multicycle_ctrl: RTL and testbench

- Control unit that drives the MIPS datapath stage.
- Decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback through a Moore FSM.
- Produces every mux select and write enable the datapath consumes, plus an ALU decoder.
- Stalls on a single-port memory ready handshake.

---
 rtl/mips_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control unit for a multicycle MIPS datapath. A Moore FSM steps through
// fetch, decode, execute, memory and writeback using op/funct from the
// instruction register. It drives every datapath mux select and write
// enable, and it contains the ALU function decoder. Memory accesses stall
// in their state until the single-port memory raises memready.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   op         in   instr[31:26]
//   funct      in   instr[5:0]
//   zero       in   ALU zero flag
//   memready   in   memory completed the current access this cycle
//   iord       out  memory address select (0=pc, 1=aluout)
//   memwrite   out  memory write enable
//   irwrite    out  instruction register load
//   regdst     out  write register select (0=rt, 1=rd)
//   memtoreg   out  writeback select (0=aluout, 1=data)
//   regwrite   out  register file write enable
//   alusrca    out  ALU A select (0=pc, 1=rs)
//   alusrcb    out  ALU B select (00=rt, 01=4, 10=signimm, 11=signimm<<2)
//   pcsrc      out  next-PC select (00=aluresult, 01=aluout, 10=jump)
//   alucontrol out  ALU function
//   pcen       out  PC enable = pcwrite | (branch & zero)
//   illegal    out  unsupported op (DECODE) / funct (EXECUTE), one cycle
//   state      out  current FSM state, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   // Encoding entered on reset. FETCH is 0, so this must stay 0.
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       pcen,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state_q, state_d;
   logic [1:0] aluop;
   logic       branch, pcwrite;
   logic       irwrite_s, memwrite_s, regwrite_s;
   logic       funct_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RESET_STATE;
      else        state_q <= state_d;
   end

   assign state = state_q;

   // Next-state and Moore output decode. Every output gets a default so
   // states that do not mention a signal drive it to 0.
   always_comb begin
      state_d    = S_FETCH;
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = 2'b00;
      branch     = 1'b0;
      pcwrite    = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            // IR and PC load only on the cycle the read completes, so a
            // stalled fetch updates them exactly once.
            irwrite_s = memready;
            pcwrite   = memready;
            state_d   = memready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = memready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
            state_d    = memready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            if (funct_ok) begin
               state_d = S_ALUWB;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_s = 1'b1;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_d = S_FETCH;  // codes 12-15 recover to FETCH
      endcase
   end

   // ALU decoder. Unknown funct falls back to add; EXECUTE flags it.
   always_comb begin
      alucontrol = 3'b010;
      funct_ok   = 1'b1;
      case (aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default: begin
                  alucontrol = 3'b010;
                  funct_ok   = 1'b0;
               end
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   // While reset is held low FETCH is displayed, but no architectural
   // state may change, so the write enables are gated by reset directly.
   assign irwrite  = irwrite_s  & reset;
   assign memwrite = memwrite_s & reset;
   assign regwrite = regwrite_s & reset;
   assign pcen     = (pcwrite | (branch & zero)) & reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

   logic       clk, reset;
   logic [5:0] op, funct;
   logic       zero, memready;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       pcen, illegal;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memready(memready), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
      .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word layout:
   // iord memwrite irwrite regdst memtoreg regwrite alusrca
   // alusrcb[1:0] pcsrc[1:0] alucontrol[2:0] pcen illegal
   localparam logic [15:0] F1     = 16'b0_0_1_0_0_0_0_01_00_010_1_0;
   localparam logic [15:0] F0     = 16'b0_0_0_0_0_0_0_01_00_010_0_0;
   localparam logic [15:0] DEC    = 16'b0_0_0_0_0_0_0_11_00_010_0_0;
   localparam logic [15:0] DECILL = 16'b0_0_0_0_0_0_0_11_00_010_0_1;
   localparam logic [15:0] MADR   = 16'b0_0_0_0_0_0_1_10_00_010_0_0;
   localparam logic [15:0] MRD    = 16'b1_0_0_0_0_0_0_00_00_010_0_0;
   localparam logic [15:0] MWB    = 16'b0_0_0_0_1_1_0_00_00_010_0_0;
   localparam logic [15:0] MWR    = 16'b1_1_0_0_0_0_0_00_00_010_0_0;
   localparam logic [15:0] EXADD  = 16'b0_0_0_0_0_0_1_00_00_010_0_0;
   localparam logic [15:0] EXSUB  = 16'b0_0_0_0_0_0_1_00_00_110_0_0;
   localparam logic [15:0] EXAND  = 16'b0_0_0_0_0_0_1_00_00_000_0_0;
   localparam logic [15:0] EXOR   = 16'b0_0_0_0_0_0_1_00_00_001_0_0;
   localparam logic [15:0] EXSLT  = 16'b0_0_0_0_0_0_1_00_00_111_0_0;
   localparam logic [15:0] EXILL  = 16'b0_0_0_0_0_0_1_00_00_010_0_1;
   localparam logic [15:0] AWB    = 16'b0_0_0_1_0_1_0_00_00_010_0_0;
   localparam logic [15:0] BRT    = 16'b0_0_0_0_0_0_1_00_01_110_1_0;
   localparam logic [15:0] BRN    = 16'b0_0_0_0_0_0_1_00_01_110_0_0;
   localparam logic [15:0] AIEX   = 16'b0_0_0_0_0_0_1_10_00_010_0_0;
   localparam logic [15:0] AIWB   = 16'b0_0_0_0_0_1_0_00_00_010_0_0;
   localparam logic [15:0] JMP    = 16'b0_0_0_0_0_0_0_00_10_010_1_0;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        memready;
      logic [3:0]  exp_state;
      logic [15:0] exp_ctl;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic m, input logic [3:0] s, input logic [15:0] c);
      vec_t v;
      v.op = o; v.funct = f; v.zero = z; v.memready = m;
      v.exp_state = s; v.exp_ctl = c;
      vecs.push_back(v);
   endtask

   function automatic logic [15:0] ctl_now();
      return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, pcsrc, alucontrol, pcen, illegal};
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   initial begin
      // R-type: add, sub, and, or, slt -- 0,1,6,7
      add(6'b000000, 6'b100000, 0, 1, 0, F1);  add(6'b000000, 6'b100000, 0, 1, 1, DEC);
      add(6'b000000, 6'b100000, 0, 1, 6, EXADD); add(6'b000000, 6'b100000, 0, 1, 7, AWB);
      add(6'b000000, 6'b100010, 0, 1, 0, F1);  add(6'b000000, 6'b100010, 0, 1, 1, DEC);
      add(6'b000000, 6'b100010, 0, 1, 6, EXSUB); add(6'b000000, 6'b100010, 0, 1, 7, AWB);
      add(6'b000000, 6'b100100, 0, 1, 0, F1);  add(6'b000000, 6'b100100, 0, 1, 1, DEC);
      add(6'b000000, 6'b100100, 0, 1, 6, EXAND); add(6'b000000, 6'b100100, 0, 1, 7, AWB);
      add(6'b000000, 6'b100101, 0, 1, 0, F1);  add(6'b000000, 6'b100101, 0, 1, 1, DEC);
      add(6'b000000, 6'b100101, 0, 1, 6, EXOR);  add(6'b000000, 6'b100101, 0, 1, 7, AWB);
      add(6'b000000, 6'b101010, 0, 1, 0, F1);  add(6'b000000, 6'b101010, 0, 1, 1, DEC);
      add(6'b000000, 6'b101010, 0, 1, 6, EXSLT); add(6'b000000, 6'b101010, 0, 1, 7, AWB);
      // addi: 0,1,9,10
      add(6'b001000, 6'b000000, 0, 1, 0, F1);  add(6'b001000, 6'b000000, 0, 1, 1, DEC);
      add(6'b001000, 6'b000000, 0, 1, 9, AIEX); add(6'b001000, 6'b000000, 0, 1, 10, AIWB);
      // sw, no stall: 0,1,2,5
      add(6'b101011, 6'b000000, 0, 1, 0, F1);  add(6'b101011, 6'b000000, 0, 1, 1, DEC);
      add(6'b101011, 6'b000000, 0, 1, 2, MADR); add(6'b101011, 6'b000000, 0, 1, 5, MWR);
      // sw, one stall cycle in MEMWR with memwrite held
      add(6'b101011, 6'b000000, 0, 1, 0, F1);  add(6'b101011, 6'b000000, 0, 1, 1, DEC);
      add(6'b101011, 6'b000000, 0, 1, 2, MADR); add(6'b101011, 6'b000000, 0, 0, 5, MWR);
      add(6'b101011, 6'b000000, 0, 1, 5, MWR);
      // beq taken / not taken
      add(6'b000100, 6'b000000, 1, 1, 0, F1);  add(6'b000100, 6'b000000, 1, 1, 1, DEC);
      add(6'b000100, 6'b000000, 1, 1, 8, BRT);
      add(6'b000100, 6'b000000, 0, 1, 0, F1);  add(6'b000100, 6'b000000, 0, 1, 1, DEC);
      add(6'b000100, 6'b000000, 0, 1, 8, BRN);
      // j: 0,1,11
      add(6'b000010, 6'b000000, 0, 1, 0, F1);  add(6'b000010, 6'b000000, 0, 1, 1, DEC);
      add(6'b000010, 6'b000000, 0, 1, 11, JMP);
      // illegal op, then illegal funct
      add(6'b111111, 6'b000000, 0, 1, 0, F1);  add(6'b111111, 6'b000000, 0, 1, 1, DECILL);
      add(6'b000000, 6'b000111, 0, 1, 0, F1);  add(6'b000000, 6'b000111, 0, 1, 1, DEC);
      add(6'b000000, 6'b000111, 0, 1, 6, EXILL);
      // lw: 3 stall cycles in FETCH, 2 in MEMRD -> 10 cycles
      add(6'b100011, 6'b000000, 0, 0, 0, F0);  add(6'b100011, 6'b000000, 0, 0, 0, F0);
      add(6'b100011, 6'b000000, 0, 0, 0, F0);  add(6'b100011, 6'b000000, 0, 1, 0, F1);
      add(6'b100011, 6'b000000, 0, 1, 1, DEC); add(6'b100011, 6'b000000, 0, 1, 2, MADR);
      add(6'b100011, 6'b000000, 0, 0, 3, MRD); add(6'b100011, 6'b000000, 0, 0, 3, MRD);
      add(6'b100011, 6'b000000, 0, 1, 3, MRD); add(6'b100011, 6'b000000, 0, 1, 4, MWB);
      // back in FETCH, held there by memready=0
      add(6'b100011, 6'b000000, 0, 0, 0, F0);

      // Power-up reset: FETCH shown, write enables forced low.
      reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0; memready = 1'b1;
      #2;
      chk("reset_state", {12'b0, state}, 16'd0);
      chk("reset_enables", {12'b0, pcen, irwrite, memwrite, regwrite}, 16'd0);
      chk("reset_decode", {alusrca, alusrcb, pcsrc, alucontrol}, {1'b0, 2'b01, 2'b00, 3'b010});

      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         op = vecs[i].op; funct = vecs[i].funct;
         zero = vecs[i].zero; memready = vecs[i].memready;
         #1;
         chk($sformatf("v%0d_state", i), {12'b0, state}, {12'b0, vecs[i].exp_state});
         chk($sformatf("v%0d_ctl", i), ctl_now(), vecs[i].exp_ctl);
         @(negedge clk);
      end

      // Reset asserted mid-MEMRD while memory is stalled.
      op = 6'b100011; funct = 6'b0; zero = 1'b0; memready = 1'b1;
      @(negedge clk);                    // DECODE
      @(negedge clk);                    // MEMADR
      memready = 1'b0;
      @(negedge clk);                    // MEMRD
      @(negedge clk);                    // still MEMRD
      #1;
      chk("memrd_hold", {12'b0, state}, 16'd3);
      #1;
      reset = 1'b0;
      #1;
      chk("async_reset_state", {12'b0, state}, 16'd0);
      memready = 1'b1;
      #1;
      chk("async_reset_enables", {12'b0, pcen, irwrite, memwrite, regwrite}, 16'd0);
      @(posedge clk);
      #1;
      chk("reset_held_state", {12'b0, state}, 16'd0);
      chk("reset_held_enables", {12'b0, pcen, irwrite, memwrite, regwrite}, 16'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("release_fetch", {12'b0, state, irwrite, pcen, 2'b00}, {12'b0, 4'd0, 1'b1, 1'b1, 2'b00});
      @(negedge clk);
      #1;
      chk("release_decode", {12'b0, state}, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
